// File: rtl/fsm_transition_checker.sv
// Passive monitor for a 3-bit control-FSM state code.
// It records illegal steps, keeps a saturating fault count and locks out after ERR_LIMIT faults.
module fsm_transition_checker #(
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state_in,
    input  logic             state_vld,
    input  logic             clr_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [2:0]       prev_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lockout,
    output logic [1:0]       chk_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2,
        ST_LOCK  = 2'd3
    } chk_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT_C = CNT_W'(ERR_LIMIT);

    // Legal codes pair up as {0,1} and {2,3}; staying put or toggling within a pair is legal.
    function automatic logic legal_step(input logic [2:0] last_code, input logic [2:0] cur_code);
        return (cur_code[2] == 1'b0) && (cur_code[2:1] == last_code[2:1]);
    endfunction

    chk_state_t       state_r, state_nxt_s;
    logic [2:0]       last_r, last_nxt_s;
    logic             fault_r, fault_nxt_s;
    logic [2:0]       fault_code_r, fault_code_nxt_s;
    logic [2:0]       prev_code_r, prev_code_nxt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s, err_cnt_inc_s;
    logic             lockout_r, lockout_nxt_s;
    logic             record_s;
    logic [2:0]       rec_prev_s;

    // Saturating increment of the fault counter.
    always_comb begin
        if (err_cnt_r == CNT_MAX_C) begin
            err_cnt_inc_s = err_cnt_r;
        end else begin
            err_cnt_inc_s = err_cnt_r + CNT_ONE_C;
        end
    end

    // Next-state and next-output logic for the checker FSM.
    always_comb begin
        state_nxt_s      = state_r;
        last_nxt_s       = last_r;
        fault_nxt_s      = fault_r;
        fault_code_nxt_s = fault_code_r;
        prev_code_nxt_s  = prev_code_r;
        err_cnt_nxt_s    = err_cnt_r;
        record_s         = 1'b0;
        rec_prev_s       = last_r;

        case (state_r)
            ST_IDLE: begin
                if (state_vld) begin
                    if (state_in == 3'd0) begin
                        last_nxt_s  = 3'd0;
                        state_nxt_s = ST_TRACK;
                    end else begin
                        record_s   = 1'b1;
                        rec_prev_s = 3'd0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (state_vld) begin
                    if (legal_step(last_r, state_in)) begin
                        last_nxt_s = state_in;
                    end else begin
                        record_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_FAULT: begin
                // A clear beats any sample arriving in the same cycle.
                if (clr_fault) begin
                    fault_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            ST_LOCK: begin
                fault_nxt_s = 1'b1;
                state_nxt_s = ST_LOCK;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (record_s) begin
            fault_code_nxt_s = state_in;
            prev_code_nxt_s  = rec_prev_s;
            err_cnt_nxt_s    = err_cnt_inc_s;
            fault_nxt_s      = 1'b1;
            if (err_cnt_inc_s >= CNT_LIMIT_C) begin
                state_nxt_s = ST_LOCK;
            end else begin
                state_nxt_s = ST_FAULT;
            end
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end

        lockout_nxt_s = (state_nxt_s == ST_LOCK);
    end

    // Checker state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_r       <= 3'd0;
            fault_r      <= 1'b0;
            fault_code_r <= 3'd0;
            prev_code_r  <= 3'd0;
            err_cnt_r    <= {CNT_W{1'b0}};
            lockout_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_r       <= last_nxt_s;
            fault_r      <= fault_nxt_s;
            fault_code_r <= fault_code_nxt_s;
            prev_code_r  <= prev_code_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
            lockout_r    <= lockout_nxt_s;
        end
    end

    assign fault      = fault_r;
    assign fault_code = fault_code_r;
    assign prev_code  = prev_code_r;
    assign err_cnt    = err_cnt_r;
    assign lockout    = lockout_r;
    assign chk_state  = state_r;

endmodule

// File: tb/tb_fsm_transition_checker.sv
// Directed bench for fsm_transition_checker: a vector table for the main flow plus
// hand-written reset sequences; a second instance with CNT_W=2 runs on the same stimulus.
module tb_fsm_transition_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] state_in;
    logic       state_vld;
    logic       clr_fault;

    logic       fault, lockout;
    logic [2:0] fault_code, prev_code;
    logic [7:0] err_cnt;
    logic [1:0] chk_state;

    logic       fault2, lockout2;
    logic [2:0] fault_code2, prev_code2;
    logic [1:0] err_cnt2;
    logic [1:0] chk_state2;

    int checks;
    int failures;

    typedef struct {
        logic       vld;
        logic [2:0] code;
        logic       clr;
        logic       e_fault;
        logic [2:0] e_code;
        logic [2:0] e_prev;
        logic [7:0] e_cnt;
        logic       e_lock;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl[$];

    fsm_transition_checker #(.ERR_LIMIT(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_vld(state_vld),
        .clr_fault(clr_fault), .fault(fault), .fault_code(fault_code),
        .prev_code(prev_code), .err_cnt(err_cnt), .lockout(lockout),
        .chk_state(chk_state)
    );

    fsm_transition_checker #(.ERR_LIMIT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_vld(state_vld),
        .clr_fault(clr_fault), .fault(fault2), .fault_code(fault_code2),
        .prev_code(prev_code2), .err_cnt(err_cnt2), .lockout(lockout2),
        .chk_state(chk_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_fault, input logic [2:0] e_code,
                           input logic [2:0] e_prev, input logic [7:0] e_cnt,
                           input logic e_lock, input logic [1:0] e_st);
        chk({tag, ".fault"},      int'(fault),      int'(e_fault));
        chk({tag, ".fault_code"}, int'(fault_code), int'(e_code));
        chk({tag, ".prev_code"},  int'(prev_code),  int'(e_prev));
        chk({tag, ".err_cnt"},    int'(err_cnt),    int'(e_cnt));
        chk({tag, ".lockout"},    int'(lockout),    int'(e_lock));
        chk({tag, ".chk_state"},  int'(chk_state),  int'(e_st));
        chk({tag, ".err_cnt_w2"}, int'(err_cnt2),   int'(e_cnt[1:0]));
        chk({tag, ".lockout_w2"}, int'(lockout2),   int'(e_lock));
    endtask

    task automatic step(input logic vld, input logic [2:0] code, input logic clr);
        @(negedge clk);
        state_vld = vld;
        state_in  = code;
        clr_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic vld, input logic [2:0] code, input logic clr,
                       input logic ef, input logic [2:0] ec, input logic [2:0] ep,
                       input logic [7:0] en, input logic el, input logic [1:0] es);
        vec_t v;
        v.vld = vld; v.code = code; v.clr = clr;
        v.e_fault = ef; v.e_code = ec; v.e_prev = ep;
        v.e_cnt = en; v.e_lock = el; v.e_st = es;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        state_vld = 1'b0;
        clr_fault = 1'b0;
        state_in  = 3'd0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        state_vld = 1'b0;
        state_in  = 3'd0;
        clr_fault = 1'b0;

        //   vld code clr | fault code prev cnt lock state
        add(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b0, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        add(1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b1, 3'd7, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b1, 3'd5, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b1, 3'd1, 1'b0, 1'b1, 3'd3, 3'd1, 8'd1, 1'b0, 2'd2);
        add(1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 3'd1, 8'd1, 1'b0, 2'd0);
        add(1'b0, 3'd5, 1'b0, 1'b0, 3'd3, 3'd1, 8'd1, 1'b0, 2'd0);
        add(1'b1, 3'd0, 1'b1, 1'b0, 3'd3, 3'd1, 8'd1, 1'b0, 2'd1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 3'd3, 3'd1, 8'd1, 1'b0, 2'd1);
        add(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd1, 8'd1, 1'b0, 2'd1);
        add(1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 3'd0, 8'd2, 1'b0, 2'd2);
        add(1'b1, 3'd6, 1'b1, 1'b0, 3'd4, 3'd0, 8'd2, 1'b0, 2'd0);
        add(1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 3'd0, 8'd3, 1'b1, 2'd3);
        add(1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 3'd0, 8'd3, 1'b1, 2'd3);
        add(1'b1, 3'd7, 1'b0, 1'b1, 3'd2, 3'd0, 8'd3, 1'b1, 2'd3);
        add(1'b1, 3'd5, 1'b1, 1'b1, 3'd2, 3'd0, 8'd3, 1'b1, 2'd3);

        do_reset();
        #1;
        chk_all("reset", 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd0);

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].code, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].e_fault, tbl[i].e_code, tbl[i].e_prev,
                    tbl[i].e_cnt, tbl[i].e_lock, tbl[i].e_st);
        end

        // Asynchronous reset pulse while in LOCK, away from any clock edge.
        @(negedge clk);
        state_vld = 1'b0;
        clr_fault = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 3'd0, 1'b0);
        chk_all("post_rst0", 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);
        step(1'b1, 3'd1, 1'b0);
        chk_all("post_rst1", 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 2'd1);

        // First sample after reset is illegal, then clear collides with a sample.
        do_reset();
        step(1'b1, 3'd2, 1'b0);
        chk_all("idle_bad", 1'b1, 3'd2, 3'd0, 8'd1, 1'b0, 2'd2);
        step(1'b1, 3'd6, 1'b1);
        chk_all("clr_wins", 1'b0, 3'd2, 3'd0, 8'd1, 1'b0, 2'd0);
        step(1'b1, 3'd0, 1'b0);
        chk_all("recheck", 1'b0, 3'd2, 3'd0, 8'd1, 1'b0, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
